// File: rtl/ysyx_24090012_exu_pkg.sv
// Shared op-code encoding, FSM state type and width-independent constants
// for the multi-cycle execute unit.
package ysyx_24090012_exu_pkg;

  localparam int OP_CODE_W = 5;
  localparam int PC_STEP   = 4;

  typedef enum logic [OP_CODE_W-1:0] {
    OP_ADD     = 5'd0,
    OP_SUB     = 5'd1,
    OP_AND     = 5'd2,
    OP_OR      = 5'd3,
    OP_XOR     = 5'd4,
    OP_SLT     = 5'd5,
    OP_SLTU    = 5'd6,
    OP_SLL     = 5'd7,
    OP_SRL     = 5'd8,
    OP_SRA     = 5'd9,
    OP_LUI     = 5'd10,
    OP_AUIPC   = 5'd11,
    OP_MEMADDR = 5'd12,
    OP_JAL     = 5'd13,
    OP_JALR    = 5'd14,
    OP_BEQ     = 5'd15,
    OP_BNE     = 5'd16,
    OP_BLT     = 5'd17,
    OP_BGE     = 5'd18,
    OP_BLTU    = 5'd19,
    OP_BGEU    = 5'd20,
    OP_MUL     = 5'd21,
    OP_MULH    = 5'd22,
    OP_MULHU   = 5'd23,
    OP_DIV     = 5'd24,
    OP_DIVU    = 5'd25,
    OP_REM     = 5'd26,
    OP_REMU    = 5'd27
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_e;

  function automatic logic is_mul(op_e op);
    return (op == OP_MUL) || (op == OP_MULH) || (op == OP_MULHU);
  endfunction

endpackage

// File: rtl/ysyx_24090012_mdu.sv
// Iterative shift-add multiplier / restoring divider, one bit per cycle.
// The first bit is processed on the start edge, so done rises XLEN-1 edges later.
module ysyx_24090012_mdu
  import ysyx_24090012_exu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            kill,
  input  logic            start,
  input  op_e             op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CW = $clog2(XLEN);

  logic            run_q;
  logic [CW-1:0]   cnt_q;
  op_e             op_q;
  logic            neg_q;
  logic [XLEN-1:0] hi_q, lo_q, m_q;

  logic            sa, sb, src_mul;
  logic [XLEN-1:0] abs_a, abs_b, src_hi, src_lo, src_m, nhi, nlo;
  logic [XLEN:0]   sum, shifted;

  // Signed ops run on magnitudes; the sign is reapplied to the final value.
  always_comb begin
    sa = 1'b0;
    sb = 1'b0;
    if (op == OP_MULH || op == OP_DIV || op == OP_REM) begin
      sa = a[XLEN-1];
      sb = b[XLEN-1];
    end
    abs_a   = sa ? -a : a;
    abs_b   = sb ? -b : b;
    src_mul = start ? is_mul(op) : is_mul(op_q);
    src_hi  = start ? '0 : hi_q;
    src_lo  = start ? (is_mul(op) ? abs_b : abs_a) : lo_q;
    src_m   = start ? (is_mul(op) ? abs_a : abs_b) : m_q;
    sum     = '0;
    shifted = '0;
    nhi     = src_hi;
    nlo     = src_lo;
    if (src_mul) begin
      sum = {1'b0, src_hi} + (src_lo[0] ? {1'b0, src_m} : '0);
      nhi = sum[XLEN:1];
      nlo = {sum[0], src_lo[XLEN-1:1]};
    end else begin
      shifted = {src_hi, src_lo[XLEN-1]};
      sum     = shifted - {1'b0, src_m};
      if (!sum[XLEN]) begin
        nhi = sum[XLEN-1:0];
        nlo = {src_lo[XLEN-2:0], 1'b1};
      end else begin
        nhi = shifted[XLEN-1:0];
        nlo = {src_lo[XLEN-2:0], 1'b0};
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_q <= 1'b0;
      cnt_q <= '0;
      op_q  <= OP_ADD;
      neg_q <= 1'b0;
      hi_q  <= '0;
      lo_q  <= '0;
      m_q   <= '0;
    end else if (kill) begin
      run_q <= 1'b0;
      cnt_q <= '0;
    end else if (start) begin
      run_q <= 1'b1;
      cnt_q <= CW'(XLEN-1);
      op_q  <= op;
      neg_q <= (op == OP_REM) ? sa : (sa ^ sb);
      hi_q  <= nhi;
      lo_q  <= nlo;
      m_q   <= src_m;
    end else if (run_q) begin
      if (cnt_q != '0) begin
        cnt_q <= cnt_q - 1'b1;
        hi_q  <= nhi;
        lo_q  <= nlo;
      end else begin
        run_q <= 1'b0;
      end
    end
  end

  assign done = run_q && (cnt_q == '0);

  logic [2*XLEN-1:0] prod, prod_s;
  logic [XLEN-1:0]   quo, rem;

  always_comb begin
    prod   = {hi_q, lo_q};
    prod_s = neg_q ? -prod : prod;
    quo    = neg_q ? -lo_q : lo_q;
    rem    = neg_q ? -hi_q : hi_q;
    case (op_q)
      OP_MUL:            result = prod_s[XLEN-1:0];
      OP_MULH, OP_MULHU: result = prod_s[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:   result = quo;
      default:           result = rem;
    endcase
  end

endmodule

// File: rtl/ysyx_24090012_exu_mc.sv
// Multi-cycle execute unit: single-cycle ALU/branch/jump, optional iterative
// MUL/DIV enabled by defining YSYX_24090012_EXU_MDU_EN.
// state | meaning
// IDLE  | in_ready=1, accepting a new op
// BUSY  | iterative MDU op in progress
// DONE  | out_* valid and held until out_ready
module ysyx_24090012_exu_mc
  import ysyx_24090012_exu_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int OP_W = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_pc,
  input  logic [XLEN-1:0] in_rs1,
  input  logic [XLEN-1:0] in_rs2,
  input  logic [XLEN-1:0] in_imm,
  input  logic [OP_W-1:0] in_op,
  input  logic            in_use_imm,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_result,
  output logic [XLEN-1:0] out_next_pc,
  output logic            out_redirect,
  output logic            out_illegal,
  input  logic            flush
);

  localparam int SHW = $clog2(XLEN);

  state_e          state;
  op_e             op;
  logic            op_hi_ok, ill, iter;
  logic [XLEN-1:0] b, pc4, res, npc;
  logic [SHW-1:0]  shamt;

  assign op       = op_e'(in_op[OP_CODE_W-1:0]);
  assign op_hi_ok = (in_op >> OP_CODE_W) == '0;
  assign b        = in_use_imm ? in_imm : in_rs2;
  assign shamt    = b[SHW-1:0];
  assign pc4      = in_pc + XLEN'(PC_STEP);
  assign in_ready = (state == S_IDLE);

  always_comb begin
    res  = '0;
    npc  = pc4;
    ill  = 1'b0;
    iter = 1'b0;
    if (!op_hi_ok) begin
      ill = 1'b1;
    end else begin
      case (op)
        OP_ADD:     res = in_rs1 + b;
        OP_SUB:     res = in_rs1 - b;
        OP_AND:     res = in_rs1 & b;
        OP_OR:      res = in_rs1 | b;
        OP_XOR:     res = in_rs1 ^ b;
        OP_SLT:     res = XLEN'($signed(in_rs1) < $signed(b));
        OP_SLTU:    res = XLEN'(in_rs1 < b);
        OP_SLL:     res = in_rs1 << shamt;
        OP_SRL:     res = in_rs1 >> shamt;
        OP_SRA:     res = $signed(in_rs1) >>> shamt;
        OP_LUI:     res = in_imm;
        OP_AUIPC:   res = in_pc + in_imm;
        OP_MEMADDR: res = in_rs1 + in_imm;
        OP_JAL: begin
          res = pc4;
          npc = in_pc + in_imm;
        end
        OP_JALR: begin
          res = pc4;
          npc = (in_rs1 + in_imm) & ~XLEN'(1);
        end
        OP_BEQ:  if (in_rs1 == in_rs2) npc = in_pc + in_imm;
        OP_BNE:  if (in_rs1 != in_rs2) npc = in_pc + in_imm;
        OP_BLT:  if ($signed(in_rs1) <  $signed(in_rs2)) npc = in_pc + in_imm;
        OP_BGE:  if ($signed(in_rs1) >= $signed(in_rs2)) npc = in_pc + in_imm;
        OP_BLTU: if (in_rs1 <  in_rs2) npc = in_pc + in_imm;
        OP_BGEU: if (in_rs1 >= in_rs2) npc = in_pc + in_imm;
`ifdef YSYX_24090012_EXU_MDU_EN
        OP_MUL, OP_MULH, OP_MULHU: iter = 1'b1;
        // Zero divisor and signed overflow finish without iterating.
        OP_DIV, OP_REM: begin
          if (b == '0)
            res = (op == OP_DIV) ? '1 : in_rs1;
          else if (in_rs1 == {1'b1, {(XLEN-1){1'b0}}} && b == '1)
            res = (op == OP_DIV) ? in_rs1 : '0;
          else
            iter = 1'b1;
        end
        OP_DIVU, OP_REMU: begin
          if (b == '0)
            res = (op == OP_DIVU) ? '1 : in_rs1;
          else
            iter = 1'b1;
        end
`endif
        default: ill = 1'b1;
      endcase
    end
  end

`ifdef YSYX_24090012_EXU_MDU_EN
  logic            mdu_start, mdu_done;
  logic [XLEN-1:0] mdu_res;

  assign mdu_start = (state == S_IDLE) && in_valid && !flush && iter;

  ysyx_24090012_mdu #(.XLEN(XLEN)) u_mdu (
    .clk    (clk),
    .rst_n  (rst_n),
    .kill   (flush),
    .start  (mdu_start),
    .op     (op),
    .a      (in_rs1),
    .b      (b),
    .done   (mdu_done),
    .result (mdu_res)
  );
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      out_valid    <= 1'b0;
      out_result   <= '0;
      out_next_pc  <= '0;
      out_redirect <= 1'b0;
      out_illegal  <= 1'b0;
    end else if (flush) begin
      state     <= S_IDLE;
      out_valid <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            out_result   <= res;
            out_next_pc  <= npc;
            out_redirect <= (npc != pc4);
            out_illegal  <= ill;
            if (iter) begin
              state <= S_BUSY;
            end else begin
              state     <= S_DONE;
              out_valid <= 1'b1;
            end
          end
        end
        S_BUSY: begin
`ifdef YSYX_24090012_EXU_MDU_EN
          if (mdu_done) begin
            state      <= S_DONE;
            out_valid  <= 1'b1;
            out_result <= mdu_res;
          end
`else
          state <= S_IDLE;
`endif
        end
        S_DONE: begin
          if (out_ready) begin
            state     <= S_IDLE;
            out_valid <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_24090012_exu_mc.sv
// Directed bench for ysyx_24090012_exu_mc with an arithmetic reference model
// and a per-cycle output checker; MDU cases build with YSYX_24090012_EXU_MDU_EN.
module tb_ysyx_24090012_exu_mc;
  import ysyx_24090012_exu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0, in_ready, in_use_imm = 1'b0;
  logic [31:0] in_pc = '0, in_rs1 = '0, in_rs2 = '0, in_imm = '0;
  logic [4:0]  in_op = '0;
  logic        out_valid, out_ready = 1'b0, out_redirect, out_illegal, flush = 1'b0;
  logic [31:0] out_result, out_next_pc;

  always #5 clk = ~clk;

  ysyx_24090012_exu_mc #(.XLEN(32), .OP_W(5)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_pc        (in_pc),
    .in_rs1       (in_rs1),
    .in_rs2       (in_rs2),
    .in_imm       (in_imm),
    .in_op        (in_op),
    .in_use_imm   (in_use_imm),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_result   (out_result),
    .out_next_pc  (out_next_pc),
    .out_redirect (out_redirect),
    .out_illegal  (out_illegal),
    .flush        (flush)
  );

  typedef struct {
    logic [31:0] res;
    logic [31:0] npc;
    logic        redir;
    logic        ill;
  } exp_t;

  exp_t exp_q[$];
  int total = 0;
  int bad = 0;

  function automatic void check(string name, logic [63:0] got, logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", name, got, want);
    end
  endfunction

  // Reference: what the architecture says each op produces, plus its latency.
  function automatic void model(input logic [4:0] op, input logic [31:0] pc, rs1, rs2, imm,
                                input logic ui, output exp_t e, output int lat);
    logic [31:0] bv, pc4;
    longint s1, sbv, s2;
    longint unsigned up;
    bv  = ui ? imm : rs2;
    pc4 = pc + 32'd4;
    s1  = longint'($signed(rs1));
    s2  = longint'($signed(rs2));
    sbv = longint'($signed(bv));
    up  = 0;
    e.res = '0;
    e.npc = pc4;
    e.ill = 1'b0;
    lat = 1;
    case (op)
      OP_ADD:     e.res = rs1 + bv;
      OP_SUB:     e.res = rs1 - bv;
      OP_AND:     e.res = rs1 & bv;
      OP_OR:      e.res = rs1 | bv;
      OP_XOR:     e.res = rs1 ^ bv;
      OP_SLT:     e.res = (s1 < sbv) ? 32'd1 : 32'd0;
      OP_SLTU:    e.res = (rs1 < bv) ? 32'd1 : 32'd0;
      OP_SLL:     e.res = rs1 << bv[4:0];
      OP_SRL:     e.res = rs1 >> bv[4:0];
      OP_SRA:     e.res = 32'(s1 >>> bv[4:0]);
      OP_LUI:     e.res = imm;
      OP_AUIPC:   e.res = pc + imm;
      OP_MEMADDR: e.res = rs1 + imm;
      OP_JAL:     begin e.res = pc4; e.npc = pc + imm; end
      OP_JALR:    begin e.res = pc4; e.npc = (rs1 + imm) & 32'hFFFF_FFFE; end
      OP_BEQ:     if (rs1 == rs2) e.npc = pc + imm;
      OP_BNE:     if (rs1 != rs2) e.npc = pc + imm;
      OP_BLT:     if (s1 < s2) e.npc = pc + imm;
      OP_BGE:     if (s1 >= s2) e.npc = pc + imm;
      OP_BLTU:    if (rs1 < rs2) e.npc = pc + imm;
      OP_BGEU:    if (rs1 >= rs2) e.npc = pc + imm;
`ifdef YSYX_24090012_EXU_MDU_EN
      OP_MUL:   begin e.res = rs1 * bv; lat = 33; end
      OP_MULH:  begin e.res = 32'((s1 * sbv) >>> 32); lat = 33; end
      OP_MULHU: begin up = {32'd0, rs1} * {32'd0, bv}; e.res = up[63:32]; lat = 33; end
      OP_DIV, OP_REM: begin
        if (bv == 0) e.res = (op == OP_DIV) ? 32'hFFFF_FFFF : rs1;
        else if (rs1 == 32'h8000_0000 && bv == 32'hFFFF_FFFF) e.res = (op == OP_DIV) ? rs1 : 32'd0;
        else begin
          e.res = (op == OP_DIV) ? 32'(s1 / sbv) : 32'(s1 % sbv);
          lat = 33;
        end
      end
      OP_DIVU, OP_REMU: begin
        if (bv == 0) e.res = (op == OP_DIVU) ? 32'hFFFF_FFFF : rs1;
        else begin
          e.res = (op == OP_DIVU) ? rs1 / bv : rs1 % bv;
          lat = 33;
        end
      end
`endif
      default: e.ill = 1'b1;
    endcase
    e.redir = (e.npc != pc4);
  endfunction

  // Whenever outputs are valid they must equal the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_valid", 64'(exp_q.size()), 64'd1);
      end else begin
        check("result", out_result, exp_q[0].res);
        check("next_pc", out_next_pc, exp_q[0].npc);
        check("redirect", out_redirect, exp_q[0].redir);
        check("illegal", out_illegal, exp_q[0].ill);
        if (out_ready) void'(exp_q.pop_front());
      end
    end
  end

  task automatic send(input logic [4:0] op, input logic [31:0] pc, rs1, rs2, imm,
                      input logic ui, output int lat);
    exp_t e;
    int exp_lat;
    int n;
    model(op, pc, rs1, rs2, imm, ui, e, exp_lat);
    @(negedge clk);
    n = 0;
    while (!in_ready && n < 50) begin @(negedge clk); n++; end
    in_op = op; in_pc = pc; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm; in_use_imm = ui;
    in_valid = 1'b1;
    exp_q.push_back(e);
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 100) begin @(posedge clk); #1; lat++; end
    check("latency", lat, exp_lat);
    check("in_ready_in_done", in_ready, 1'b0);
  endtask

  task automatic drain(input int hold);
    repeat (hold) begin @(posedge clk); #1; end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("valid_drop", out_valid, 1'b0);
    check("ready_after_done", in_ready, 1'b1);
  endtask

  task automatic op_test(input logic [4:0] op, input logic [31:0] pc, rs1, rs2, imm,
                         input logic ui, input int hold);
    int lat;
    send(op, pc, rs1, rs2, imm, ui, lat);
    drain(hold);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int lat;
    int seen;
    #12;
    check("rst_valid", out_valid, 1'b0);
    check("rst_result", out_result, 32'd0);
    check("rst_next_pc", out_next_pc, 32'd0);
    check("rst_redirect", out_redirect, 1'b0);
    check("rst_illegal", out_illegal, 1'b0);
    check("rst_in_ready", in_ready, 1'b1);
    @(negedge clk) rst_n = 1'b1;

    // Overflowing ADD, 1-cycle latency
    send(OP_ADD, 32'h8000_0000, 32'h7FFF_FFFF, 32'd1, 32'd0, 1'b0, lat);
    check("add_lat_lit", lat, 1);
    check("add_res_lit", out_result, 32'h8000_0000);
    check("add_npc_lit", out_next_pc, 32'h8000_0004);
    drain(0);

    // Taken backward BNE with downstream stall
    send(OP_BNE, 32'h8000_0010, 32'd1, 32'd2, 32'hFFFF_FFF0, 1'b0, lat);
    check("bne_npc_lit", out_next_pc, 32'h8000_0000);
    check("bne_redir_lit", out_redirect, 1'b1);
    repeat (3) begin
      @(posedge clk); #1;
      check("bne_hold_valid", out_valid, 1'b1);
      check("bne_hold_npc", out_next_pc, 32'h8000_0000);
    end
    drain(0);

    send(OP_JALR, 32'h8000_0020, 32'h8000_0103, 32'd0, 32'd0, 1'b1, lat);
    check("jalr_npc_lit", out_next_pc, 32'h8000_0102);
    check("jalr_res_lit", out_result, 32'h8000_0024);
    drain(1);

    op_test(OP_SUB,     32'h100, 32'd5, 32'd7, 32'd0, 1'b0, 0);
    op_test(OP_AND,     32'h104, 32'h0000_F0F0, 32'd0, 32'h0000_00FF, 1'b1, 1);
    op_test(OP_OR,      32'h108, 32'h1200_0000, 32'h0000_0034, 32'd0, 1'b0, 0);
    op_test(OP_XOR,     32'h10C, 32'hFFFF_0000, 32'h0F0F_0F0F, 32'd0, 1'b0, 2);
    op_test(OP_SLT,     32'h110, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, 0);
    op_test(OP_SLTU,    32'h114, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, 0);
    op_test(OP_SLL,     32'h118, 32'd1, 32'h21, 32'd0, 1'b0, 0);
    op_test(OP_SRL,     32'h11C, 32'h8000_0000, 32'd31, 32'd0, 1'b0, 0);
    op_test(OP_SRA,     32'h120, 32'h8000_0000, 32'd0, 32'd4, 1'b1, 1);
    op_test(OP_LUI,     32'h124, 32'd0, 32'd0, 32'h1234_5000, 1'b1, 0);
    op_test(OP_AUIPC,   32'h8000_0128, 32'd0, 32'd0, 32'h0000_1000, 1'b1, 0);
    op_test(OP_MEMADDR, 32'h12C, 32'h2000_0000, 32'd0, 32'hFFFF_FFFC, 1'b1, 0);
    op_test(OP_JAL,     32'hFFFF_FFFC, 32'd0, 32'd0, 32'd8, 1'b1, 0);
    op_test(OP_BEQ,     32'h200, 32'd9, 32'd9, 32'h40, 1'b1, 0);
    op_test(OP_BEQ,     32'h204, 32'd9, 32'd8, 32'h40, 1'b1, 0);
    op_test(OP_BLT,     32'h208, 32'hFFFF_FFFF, 32'd1, 32'h10, 1'b1, 0);
    op_test(OP_BGE,     32'h20C, 32'hFFFF_FFFF, 32'd1, 32'h10, 1'b1, 0);
    op_test(OP_BLTU,    32'h210, 32'hFFFF_FFFF, 32'd1, 32'h10, 1'b1, 0);
    op_test(OP_BGEU,    32'h214, 32'hFFFF_FFFF, 32'd1, 32'h10, 1'b1, 0);
    op_test(5'd31,      32'h218, 32'd3, 32'd4, 32'd0, 1'b0, 0);

`ifndef YSYX_24090012_EXU_MDU_EN
    send(OP_MUL, 32'h300, 32'd6, 32'd7, 32'd0, 1'b0, lat);
    check("mul_off_lat_lit", lat, 1);
    check("mul_off_ill_lit", out_illegal, 1'b1);
    check("mul_off_res_lit", out_result, 32'd0);
    drain(0);
`else
    send(OP_DIVU, 32'h300, 32'd100, 32'd7, 32'd0, 1'b0, lat);
    check("divu_lat_lit", lat, 33);
    check("divu_res_lit", out_result, 32'd14);
    drain(0);
    send(OP_REM, 32'h304, 32'hFFFF_FFF9, 32'd2, 32'd0, 1'b0, lat);
    check("rem_res_lit", out_result, 32'hFFFF_FFFF);
    drain(0);
    send(OP_DIV, 32'h308, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1'b0, lat);
    check("div_ovf_lat_lit", lat, 1);
    check("div_ovf_res_lit", out_result, 32'h8000_0000);
    drain(0);
    send(OP_DIVU, 32'h30C, 32'd1234, 32'd0, 32'd0, 1'b0, lat);
    check("divu0_res_lit", out_result, 32'hFFFF_FFFF);
    drain(0);
    op_test(OP_MUL,   32'h310, 32'hFFFF_FFFD, 32'd7, 32'd0, 1'b0, 0);
    op_test(OP_MULH,  32'h314, 32'hFFFF_FFFD, 32'h4000_0000, 32'd0, 1'b0, 0);
    op_test(OP_MULHU, 32'h318, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 1'b0, 0);
    op_test(OP_REMU,  32'h31C, 32'd100, 32'd7, 32'd0, 1'b0, 0);
    op_test(OP_REM,   32'h320, 32'd77, 32'd0, 32'd0, 1'b0, 0);

    // Flush during the tenth BUSY cycle; no result may ever appear
    @(negedge clk);
    in_op = OP_DIVU; in_rs1 = 32'd500; in_rs2 = 32'd3; in_use_imm = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("busy_flush_idle", in_ready, 1'b1);
    seen = 0;
    repeat (40) begin @(posedge clk); #1; if (out_valid) seen++; end
    check("busy_flush_no_valid", seen, 0);

    // Reset mid-BUSY clears outputs at once and discards the op
    @(negedge clk);
    in_op = OP_DIVU; in_pc = 32'h400; in_rs1 = 32'd500; in_rs2 = 32'd3; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("busy_rst_npc", out_next_pc, 32'd0);
    check("busy_rst_valid", out_valid, 1'b0);
    @(negedge clk) rst_n = 1'b1;
    seen = 0;
    repeat (40) begin @(posedge clk); #1; if (out_valid) seen++; end
    check("busy_rst_no_valid", seen, 0);
`endif

    // Flush in DONE beats a same-cycle out_ready
    send(OP_ADD, 32'h500, 32'd1, 32'd2, 32'd0, 1'b0, lat);
    flush = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    out_ready = 1'b0;
    check("done_flush_valid", out_valid, 1'b0);
    check("done_flush_idle", in_ready, 1'b1);
    exp_q.delete();

    // Flush beats a same-cycle in_valid in IDLE
    @(negedge clk);
    in_op = OP_ADD; in_rs1 = 32'd3; in_rs2 = 32'd4; in_valid = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    flush = 1'b0;
    check("idle_flush_no_accept", in_ready, 1'b1);
    check("idle_flush_valid", out_valid, 1'b0);

    // Asynchronous reset while holding a result in DONE
    send(OP_JAL, 32'h600, 32'd0, 32'd0, 32'h80, 1'b1, lat);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_valid", out_valid, 1'b0);
    check("async_rst_result", out_result, 32'd0);
    check("async_rst_npc", out_next_pc, 32'd0);
    check("async_rst_redirect", out_redirect, 1'b0);
    exp_q.delete();
    @(negedge clk) rst_n = 1'b1;

    op_test(OP_XOR, 32'h700, 32'hA5A5_A5A5, 32'd0, 32'hFFFF_FFFF, 1'b1, 0);
    repeat (2) @(posedge clk);
    check("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
